// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction plus register operands into an ALU
// operation and holds it in a valid/ready output register with stall and flush support.
module alu_issue_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       alu_in1,
  output logic [31:0]       alu_in2,
  output logic [4:0]        alu_ctl,
  output logic              alu_sign,
  output logic [4:0]        wr_reg,
  output logic              illegal,
  output logic [CNT_W-1:0]  issue_count
);

  localparam logic [4:0] CTL_AND = 5'b00000;
  localparam logic [4:0] CTL_OR  = 5'b00001;
  localparam logic [4:0] CTL_ADD = 5'b00010;
  localparam logic [4:0] CTL_SUB = 5'b00110;
  localparam logic [4:0] CTL_SLT = 5'b00111;
  localparam logic [4:0] CTL_NOR = 5'b01100;
  localparam logic [4:0] CTL_XOR = 5'b01101;
  localparam logic [4:0] CTL_SLL = 5'b10000;
  localparam logic [4:0] CTL_SRL = 5'b11000;
  localparam logic [4:0] CTL_SRA = 5'b11001;
  localparam logic [4:0] CTL_MUL = 5'b11010;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  ctl;
    logic        sign;
    logic [4:0]  wr;
    logic        ill;
  } alu_op_t;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [31:0] sx;
  logic [31:0] zx;
  logic        unused_rs_field;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign rt_f  = instr[20:16];
  assign rd_f  = instr[15:11];
  assign shamt = instr[10:6];
  assign sx    = {{16{instr[15]}}, instr[15:0]};
  assign zx    = {16'h0000, instr[15:0]};
  // rs operand arrives pre-read in rs_data; the field itself is not needed here
  assign unused_rs_field = ^instr[25:21];

  alu_op_t dec;

  // Instruction decode
  always_comb begin
    dec      = '0;
    dec.in1  = rs_data;
    dec.in2  = rt_data;
    dec.wr   = rt_f;
    unique case (op)
      6'h00: begin
        dec.wr = rd_f;
        unique case (fn)
          6'h00:   begin dec.ctl = CTL_SLL; dec.in1 = {27'b0, shamt}; end
          6'h02:   begin dec.ctl = CTL_SRL; dec.in1 = {27'b0, shamt}; end
          6'h03:   begin dec.ctl = CTL_SRA; dec.in1 = {27'b0, shamt}; end
          6'h04:   dec.ctl = CTL_SLL;
          6'h06:   dec.ctl = CTL_SRL;
          6'h07:   dec.ctl = CTL_SRA;
          6'h20:   begin dec.ctl = CTL_ADD; dec.sign = 1'b1; end
          6'h21:   dec.ctl = CTL_ADD;
          6'h22:   begin dec.ctl = CTL_SUB; dec.sign = 1'b1; end
          6'h23:   dec.ctl = CTL_SUB;
          6'h24:   dec.ctl = CTL_AND;
          6'h25:   dec.ctl = CTL_OR;
          6'h26:   dec.ctl = CTL_XOR;
          6'h27:   dec.ctl = CTL_NOR;
          6'h2A:   begin dec.ctl = CTL_SLT; dec.sign = 1'b1; end
          6'h2B:   dec.ctl = CTL_SLT;
          default: dec.ill = 1'b1;
        endcase
      end
      6'h1C: begin
        if (fn == 6'h02) begin
          dec.ctl = CTL_MUL;
          dec.wr  = rd_f;
        end else begin
          dec.ill = 1'b1;
        end
      end
      6'h08:   begin dec.ctl = CTL_ADD; dec.in2 = sx; dec.sign = 1'b1; end
      6'h09:   begin dec.ctl = CTL_ADD; dec.in2 = sx; end
      6'h0A:   begin dec.ctl = CTL_SLT; dec.in2 = sx; dec.sign = 1'b1; end
      6'h0B:   begin dec.ctl = CTL_SLT; dec.in2 = sx; end
      6'h0C:   begin dec.ctl = CTL_AND; dec.in2 = zx; end
      6'h0D:   begin dec.ctl = CTL_OR;  dec.in2 = zx; end
      6'h0E:   begin dec.ctl = CTL_XOR; dec.in2 = zx; end
      6'h0F:   begin dec.ctl = CTL_SLL; dec.in1 = 32'd16; dec.in2 = zx; end
      6'h23:   begin dec.ctl = CTL_ADD; dec.in2 = sx; end
      6'h2B:   begin dec.ctl = CTL_ADD; dec.in2 = sx; dec.wr = 5'd0; end
      6'h04,
      6'h05:   begin dec.ctl = CTL_SUB; dec.wr = 5'd0; end
      default: dec.ill = 1'b1;
    endcase
    // Unsupported encodings issue as a harmless zeroed op flagged illegal
    if (dec.ill) begin
      dec.in1 = '0;
      dec.in2 = '0;
      dec.ctl = CTL_AND;
      dec.wr  = 5'd0;
    end
  end

  logic             valid_q, valid_d;
  alu_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_c;

  assign in_ready_c = !valid_q || out_ready || flush;
  assign in_ready   = in_ready_c;

  // Output register next-state: flush wins over load, load wins over drain
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready_c) begin
      valid_d = 1'b1;
      op_d    = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (valid_q && out_ready && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_in1     = op_q.in1;
  assign alu_in2     = op_q.in2;
  assign alu_ctl     = op_q.ctl;
  assign alu_sign    = op_q.sign;
  assign wr_reg      = op_q.wr;
  assign illegal     = op_q.ill;
  assign issue_count = cnt_q;

endmodule
